// File: rtl/regfile_wb_arbiter_if.sv
// Bus bundle for the write-back arbiter: two producer handshakes, the register file write port,
// and the decode-stage hazard query.
interface regfile_wb_arbiter_if #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 2
);
    localparam int unsigned CntW = $clog2(DEPTH) + 1;

    logic              req0_valid;
    logic              req0_ready;
    logic [ADDR_W-1:0] req0_rd;
    logic [DATA_W-1:0] req0_data;
    logic              req1_valid;
    logic              req1_ready;
    logic [ADDR_W-1:0] req1_rd;
    logic [DATA_W-1:0] req1_data;
    logic              RegWrite;
    logic [ADDR_W-1:0] RD;
    logic [DATA_W-1:0] WriteData;
    logic [ADDR_W-1:0] RS1;
    logic [ADDR_W-1:0] RS2;
    logic              stall;
    logic [CntW-1:0]   fifo0_count;
    logic [CntW-1:0]   fifo1_count;

    modport slave (
        input  req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data, RS1, RS2,
        output req0_ready, req1_ready, RegWrite, RD, WriteData, stall, fifo0_count, fifo1_count
    );

    modport master (
        output req0_valid, req0_rd, req0_data, req1_valid, req1_rd, req1_data, RS1, RS2,
        input  req0_ready, req1_ready, RegWrite, RD, WriteData, stall, fifo0_count, fifo1_count
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter sharing one register file write port between two FIFOs.
// Optional macro REGFILE_WB_X0_DISCARD_EN drops writes to x0 and ignores x0 in the hazard check.
module regfile_wb_arbiter #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DEPTH  = 2
) (
    input logic                  clk,
    input logic                  reset,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned CntW = PtrW + 1;

    logic [ADDR_W-1:0] rd_mem_q   [2][DEPTH];
    logic [ADDR_W-1:0] rd_mem_d   [2][DEPTH];
    logic [DATA_W-1:0] data_mem_q [2][DEPTH];
    logic [DATA_W-1:0] data_mem_d [2][DEPTH];
    logic [PtrW-1:0]   wptr_q [2];
    logic [PtrW-1:0]   wptr_d [2];
    logic [PtrW-1:0]   rptr_q [2];
    logic [PtrW-1:0]   rptr_d [2];
    logic [CntW-1:0]   cnt_q  [2];
    logic [CntW-1:0]   cnt_d  [2];
    logic              rr_q, rr_d;
    logic              regwrite_q, regwrite_d;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic [1:0]        in_valid, ready, push, pop, nonempty;
    logic [ADDR_W-1:0] in_rd   [2];
    logic [DATA_W-1:0] in_data [2];
    logic              grant_any, grant_idx;
    logic              rs1_en, rs2_en, hit;
    logic [PtrW-1:0]   idx;

    assign in_valid   = {bus.req1_valid, bus.req0_valid};
    assign in_rd[0]   = bus.req0_rd;
    assign in_rd[1]   = bus.req1_rd;
    assign in_data[0] = bus.req0_data;
    assign in_data[1] = bus.req1_data;

`ifdef REGFILE_WB_X0_DISCARD_EN
    assign rs1_en = (bus.RS1 != '0);
    assign rs2_en = (bus.RS2 != '0);
`else
    assign rs1_en = 1'b1;
    assign rs2_en = 1'b1;
`endif

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            nonempty[i] = (cnt_q[i] != '0);
            ready[i]    = (cnt_q[i] < CntW'(DEPTH));
`ifdef REGFILE_WB_X0_DISCARD_EN
            // x0 writes complete the handshake but are never stored.
            push[i]     = in_valid[i] && ready[i] && (in_rd[i] != '0);
`else
            push[i]     = in_valid[i] && ready[i];
`endif
        end
        grant_any = |nonempty;
        grant_idx = (&nonempty) ? rr_q : nonempty[1];
        pop       = '0;
        if (grant_any) pop[grant_idx] = 1'b1;
    end

    always_comb begin
        rd_mem_d   = rd_mem_q;
        data_mem_d = data_mem_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        for (int i = 0; i < 2; i++) begin
            if (push[i]) begin
                rd_mem_d[i][wptr_q[i]]   = in_rd[i];
                data_mem_d[i][wptr_q[i]] = in_data[i];
                wptr_d[i]                = wptr_q[i] + PtrW'(1);
            end
            if (pop[i]) rptr_d[i] = rptr_q[i] + PtrW'(1);
            cnt_d[i] = cnt_q[i] + CntW'(push[i]) - CntW'(pop[i]);
        end
        rr_d       = grant_any ? ~grant_idx : rr_q;
        regwrite_d = grant_any;
        rd_d       = rd_q;
        wdata_d    = wdata_q;
        if (grant_any) begin
            rd_d    = rd_mem_q[grant_idx][rptr_q[grant_idx]];
            wdata_d = data_mem_q[grant_idx][rptr_q[grant_idx]];
        end
    end

    // Hazard: any live FIFO entry or the write currently on the port.
    always_comb begin
        hit = regwrite_q && ((rs1_en && rd_q == bus.RS1) || (rs2_en && rd_q == bus.RS2));
        idx = '0;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < int'(DEPTH); k++) begin
                idx = rptr_q[i] + PtrW'(k);
                if (CntW'(k) < cnt_q[i]) begin
                    if ((rs1_en && rd_mem_q[i][idx] == bus.RS1) ||
                        (rs2_en && rd_mem_q[i][idx] == bus.RS2)) begin
                        hit = 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                for (int j = 0; j < int'(DEPTH); j++) begin
                    rd_mem_q[i][j]   <= '0;
                    data_mem_q[i][j] <= '0;
                end
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            rr_q       <= 1'b0;
            regwrite_q <= 1'b0;
            rd_q       <= '0;
            wdata_q    <= '0;
        end else begin
            rd_mem_q   <= rd_mem_d;
            data_mem_q <= data_mem_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            rr_q       <= rr_d;
            regwrite_q <= regwrite_d;
            rd_q       <= rd_d;
            wdata_q    <= wdata_d;
        end
    end

    assign bus.req0_ready  = ready[0];
    assign bus.req1_ready  = ready[1];
    assign bus.RegWrite    = regwrite_q;
    assign bus.RD          = rd_q;
    assign bus.WriteData   = wdata_q;
    assign bus.stall       = hit;
    assign bus.fifo0_count = cnt_q[0];
    assign bus.fifo1_count = cnt_q[1];
endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: per-requester scoreboards plus scenario tasks.
module tb_regfile_wb_arbiter;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned DEPTH  = 2;
    typedef logic [ADDR_W+DATA_W-1:0] ent_t;

    logic clk;
    logic reset;
    int   errors = 0;
    int   checks = 0;
    ent_t q0[$];
    ent_t q1[$];
    int   got_rd[$];
    int   got_cyc[$];
    bit   saw_full;

    regfile_wb_arbiter_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) bus ();

    regfile_wb_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit kept(input logic [ADDR_W-1:0] rd);
`ifdef REGFILE_WB_X0_DISCARD_EN
        return rd != '0;
`else
        return 1'b1;
`endif
    endfunction

    // Expected writes are recorded at the accepting edge.
    always @(posedge clk) begin
        if (!reset) begin
            if (bus.req0_valid && bus.req0_ready && kept(bus.req0_rd))
                q0.push_back({bus.req0_rd, bus.req0_data});
            if (bus.req1_valid && bus.req1_ready && kept(bus.req1_rd))
                q1.push_back({bus.req1_rd, bus.req1_data});
        end
    end

    always @(posedge reset) begin
        q0.delete();
        q1.delete();
    end

    // Every register file write must be the oldest outstanding entry of one requester.
    always @(negedge clk) begin
        ent_t got;
        if (!reset && bus.RegWrite === 1'b1) begin
            got = {bus.RD, bus.WriteData};
            checks++;
            if (q0.size() > 0 && q0[0] === got) void'(q0.pop_front());
            else if (q1.size() > 0 && q1[0] === got) void'(q1.pop_front());
            else begin
                errors++;
                $display("FAIL scoreboard: got rd=%0d data=%0h, expected head q0=%0h q1=%0h",
                         bus.RD, bus.WriteData, (q0.size() > 0) ? q0[0] : '0,
                         (q1.size() > 0) ? q1[0] : '0);
            end
        end
    end

    task automatic idle_inputs();
        bus.req0_valid = 1'b0; bus.req0_rd = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_rd = '0; bus.req1_data = '0;
    endtask

    task automatic mid_cycle_reset();
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        bus.RS1 = 5'd31; bus.RS2 = 5'd31;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd3; bus.req0_data = 64'd33;
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd4; bus.req1_data = 64'd44;
        @(negedge clk);
        idle_inputs();
        bus.RS1 = 5'd3;
        checks++;
        if (bus.fifo0_count !== 2'd1 || bus.fifo1_count !== 2'd1) begin
            errors++;
            $display("FAIL pre_reset_counts: got %0d/%0d, expected 1/1",
                     bus.fifo0_count, bus.fifo1_count);
        end
        #1;
        checks++;
        if (bus.stall !== 1'b1) begin
            errors++; $display("FAIL pre_reset_stall: got %b, expected 1", bus.stall);
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (bus.fifo0_count !== '0 || bus.fifo1_count !== '0) begin
            errors++;
            $display("FAIL reset_counts: got %0d/%0d, expected 0/0",
                     bus.fifo0_count, bus.fifo1_count);
        end
        checks++;
        if (bus.RegWrite !== 1'b0 || bus.RD !== '0 || bus.WriteData !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b rd=%0d data=%0h, expected 0/0/0",
                     bus.RegWrite, bus.RD, bus.WriteData);
        end
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b, expected 0", bus.stall);
        end
        @(negedge clk);
        reset = 1'b0;
        bus.RS1 = 5'd31;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.RegWrite !== 1'b0) begin
            errors++; $display("FAIL reset_discard: got RegWrite=%b, expected 0", bus.RegWrite);
        end
    endtask

    task automatic test_single_write();
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd7; bus.req0_data = 64'd99;
        @(negedge clk);
        idle_inputs();
        checks++;
        if (bus.fifo0_count !== 2'd1 || bus.RegWrite !== 1'b0) begin
            errors++;
            $display("FAIL single_queued: got count=%0d we=%b, expected 1/0",
                     bus.fifo0_count, bus.RegWrite);
        end
        @(negedge clk);
        checks++;
        if (bus.RegWrite !== 1'b1 || bus.RD !== 5'd7 || bus.WriteData !== 64'd99) begin
            errors++;
            $display("FAIL single_write: got we=%b rd=%0d data=%0d, expected 1/7/99",
                     bus.RegWrite, bus.RD, bus.WriteData);
        end
        @(negedge clk);
        checks++;
        if (bus.RegWrite !== 1'b0 || bus.RD !== 5'd7 || bus.WriteData !== 64'd99) begin
            errors++;
            $display("FAIL single_hold: got we=%b rd=%0d data=%0d, expected 0/7/99",
                     bus.RegWrite, bus.RD, bus.WriteData);
        end
    endtask

    task automatic run_streams(input int n0, input int base0, input int n1, input int base1,
                               input int max_cyc);
        int i0 = 0;
        int i1 = 0;
        got_rd.delete();
        got_cyc.delete();
        saw_full = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            @(negedge clk);
            if (bus.RegWrite === 1'b1) begin
                got_rd.push_back(int'(bus.RD));
                got_cyc.push_back(c);
            end
            if (bus.fifo1_count == 2'd2) begin
                saw_full = 1'b1;
                checks++;
                if (bus.req1_ready !== 1'b0) begin
                    errors++; $display("FAIL full_ready: got req1_ready=%b, expected 0",
                                       bus.req1_ready);
                end
            end
            bus.req0_valid = (i0 < n0);
            bus.req0_rd    = ADDR_W'(base0 + i0);
            bus.req0_data  = 64'hA000 + 64'(base0 + i0);
            bus.req1_valid = (i1 < n1);
            bus.req1_rd    = ADDR_W'(base1 + i1);
            bus.req1_data  = 64'hB000 + 64'(base1 + i1);
            @(posedge clk);
            if (bus.req0_valid && bus.req0_ready) i0++;
            if (bus.req1_valid && bus.req1_ready) i1++;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_contention();
        int exp_rd[6];
        exp_rd = '{1, 11, 2, 12, 3, 13};
        mid_cycle_reset();
        checks++;
        if (bus.RD !== '0 || bus.WriteData !== '0) begin
            errors++;
            $display("FAIL reset_clears_hold: got rd=%0d data=%0d, expected 0/0",
                     bus.RD, bus.WriteData);
        end
        @(negedge clk);
        reset = 1'b0;
        run_streams(3, 1, 3, 11, 12);
        checks++;
        if (got_rd.size() != 6) begin
            errors++; $display("FAIL contention_count: got %0d writes, expected 6", got_rd.size());
        end
        for (int k = 0; k < 6 && k < got_rd.size(); k++) begin
            checks++;
            if (got_rd[k] != exp_rd[k]) begin
                errors++;
                $display("FAIL contention_order[%0d]: got rd=%0d, expected %0d",
                         k, got_rd[k], exp_rd[k]);
            end
        end
        if (got_cyc.size() == 6) begin
            checks++;
            if (got_cyc[5] - got_cyc[0] != 5) begin
                errors++;
                $display("FAIL contention_gapless: got span %0d, expected 5",
                         got_cyc[5] - got_cyc[0]);
            end
        end
    endtask

    task automatic test_backpressure();
        run_streams(6, 20, 3, 16, 20);
        checks++;
        if (!saw_full) begin
            errors++; $display("FAIL backpressure_full: got saw_full=0, expected 1");
        end
        checks++;
        if (got_rd.size() != 9) begin
            errors++; $display("FAIL backpressure_count: got %0d writes, expected 9",
                               got_rd.size());
        end
    endtask

    task automatic test_hazard();
        @(negedge clk);
        bus.RS1 = 5'd5;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL hazard_idle: got stall=%b, expected 0", bus.stall);
        end
        bus.req1_valid = 1'b1; bus.req1_rd = 5'd5; bus.req1_data = 64'd55;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.stall !== 1'b1 || bus.RegWrite !== 1'b0) begin
            errors++; $display("FAIL hazard_pending: got stall=%b we=%b, expected 1/0",
                               bus.stall, bus.RegWrite);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.stall !== 1'b1 || bus.RegWrite !== 1'b1) begin
            errors++; $display("FAIL hazard_writing: got stall=%b we=%b, expected 1/1",
                               bus.stall, bus.RegWrite);
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL hazard_clear: got stall=%b, expected 0", bus.stall);
        end
        bus.RS1 = 5'd31;
    endtask

    task automatic test_x0();
        bit en;
`ifdef REGFILE_WB_X0_DISCARD_EN
        en = 1'b1;
`else
        en = 1'b0;
`endif
        @(negedge clk);
        bus.req0_valid = 1'b1; bus.req0_rd = 5'd0; bus.req0_data = 64'd1;
        @(negedge clk);
        idle_inputs();
        bus.RS1 = 5'd0;
        #1;
        checks++;
        if (bus.fifo0_count !== (en ? 2'd0 : 2'd1)) begin
            errors++; $display("FAIL x0_count: got %0d, expected %0d",
                               bus.fifo0_count, en ? 0 : 1);
        end
        checks++;
        if (bus.stall !== !en) begin
            errors++; $display("FAIL x0_stall: got %b, expected %b", bus.stall, !en);
        end
        @(negedge clk);
        checks++;
        if (en ? (bus.RegWrite !== 1'b0)
               : (bus.RegWrite !== 1'b1 || bus.RD !== '0 || bus.WriteData !== 64'd1)) begin
            errors++;
            $display("FAIL x0_write: got we=%b rd=%0d data=%0d, expected we=%b", bus.RegWrite,
                     bus.RD, bus.WriteData, !en);
        end
        bus.RS1 = 5'd31;
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_backpressure();
        test_hazard();
        test_x0();
        repeat (4) @(negedge clk);
        checks++;
        if (q0.size() != 0 || q1.size() != 0) begin
            errors++; $display("FAIL drained: got q0=%0d q1=%0d outstanding, expected 0/0",
                               q0.size(), q1.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
